// File: rtl/ram_dma_engine_pkg.sv
// Shared encodings for the RAM DMA engine: operation codes, FSM states and default widths.
package ram_dma_engine_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 32;

    typedef logic [1:0] op_t;
    typedef logic [1:0] state_t;

    localparam op_t OP_COPY = 2'd0;
    localparam op_t OP_FILL = 2'd1;
    localparam op_t OP_SUM  = 2'd2;
    localparam op_t OP_RSVD = 2'd3;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/ram_dma_engine.sv
// Bus initiator on the data-RAM port: block copy, block fill and wrapping 32-bit checksum.
module ram_dma_engine
    import ram_dma_engine_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_data,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic [AW:0]   count,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [AW:0] ONE = (AW+1)'(1);

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [AW-1:0] src_q, src_d, dst_q, dst_d;
    logic [AW:0]   len_q, len_d, idx_q, idx_d, count_q, count_d;
    logic [DW-1:0] fill_q, fill_d, data_q, data_d, result_q, result_d;
    logic [AW:0]   idx_next;
    logic          last;

    assign idx_next = idx_q + ONE;
    assign last     = (idx_next == len_q);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        fill_d   = fill_q;
        idx_d    = idx_q;
        count_d  = count_q;
        data_d   = data_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = len;
                    fill_d  = fill_data;
                    idx_d   = '0;
                    count_d = '0;
                    if (op == OP_SUM) result_d = '0;
                    if (len == '0 || op == OP_RSVD) state_d = ST_DONE;
                    else if (op == OP_FILL)         state_d = ST_WRITE;
                    else                            state_d = ST_READ;
                end
            end
            ST_READ: begin
                data_d = mem_dout;
                if (op_q == OP_SUM) begin
                    result_d = result_q + mem_dout;
                    idx_d    = idx_next;
                    count_d  = count_q + ONE;
                    state_d  = (last || abort) ? ST_DONE : ST_READ;
                end else begin
                    // An aborted copy read is dropped: the word never reaches WRITE.
                    state_d = abort ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                idx_d   = idx_next;
                count_d = count_q + ONE;
                if (last || abort)       state_d = ST_DONE;
                else if (op_q == OP_COPY) state_d = ST_READ;
                else                      state_d = ST_WRITE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_COPY;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            fill_q   <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            data_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            fill_q   <= fill_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            data_q   <= data_d;
            result_q <= result_d;
        end
    end

    // Bus outputs decode only registered state, so reset silences the port at once.
    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        if (state_q == ST_READ) begin
            mem_addr = src_q + idx_q[AW-1:0];
        end else if (state_q == ST_WRITE) begin
            mem_addr = dst_q + idx_q[AW-1:0];
            mem_din  = (op_q == OP_COPY) ? data_q : fill_q;
        end
    end

    assign mem_we = (state_q == ST_WRITE);
    assign busy   = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign count  = count_q;

endmodule

// File: tb/tb_ram_dma_engine.sv
// Directed bench for ram_dma_engine with a behavioural 1024x32 RAM on its memory port.
module tb_ram_dma_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [9:0]  src_addr;
    logic [9:0]  dst_addr;
    logic [10:0] len;
    logic [31:0] fill_data;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [10:0] count;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] ram [0:1023];
    logic        tb_we;
    logic [9:0]  tb_addr;
    logic [31:0] tb_data;

    int checks;
    int failures;

    ram_dma_engine dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
        .result(result), .count(count), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: DUT writes take priority; the bench port is only used while the DUT is idle.
    assign mem_dout = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_we)     ram[mem_addr] <= mem_din;
        else if (tb_we) ram[tb_addr]  <= tb_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        tb_addr = a[9:0];
        tb_data = d;
        tb_we   = 1'b1;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    // Pulses start, then counts busy and write cycles until done (bounded).
    task automatic run_op(input logic [1:0] o, input int s, input int d, input int n,
                          input logic [31:0] f, output int busy_n, output int we_n,
                          output int cyc, output int cnt, output int done_after);
        busy_n = 0; we_n = 0; cyc = 0; cnt = -1; done_after = -1;
        @(negedge clk);
        op = o; src_addr = s[9:0]; dst_addr = d[9:0]; len = n[10:0]; fill_data = f;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 4000; k++) begin
            if (busy)   busy_n++;
            if (mem_we) we_n++;
            if (done) begin
                cyc = k;
                cnt = int'(count);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        done_after = int'(done);
    endtask

    int bn, wn, cy, cn, da, wcount;
    logic hit;

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; start = 1'b0; op = 2'd0; src_addr = '0; dst_addr = '0;
        len = '0; fill_data = '0; abort = 1'b0;
        tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   32'(busy),     32'd0);
        check("reset_done",   32'(done),     32'd0);
        check("reset_we",     32'(mem_we),   32'd0);
        check("reset_addr",   32'(mem_addr), 32'd0);
        check("reset_din",    mem_din,       32'd0);
        check("reset_result", result,        32'd0);
        check("reset_count",  32'(count),    32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 1024; i++) poke(i, 32'd0);
        for (int i = 0; i < 4; i++) poke(i, 32'(i + 1));

        // COPY 4 words 0..3 -> 100..103
        run_op(2'd0, 0, 100, 4, 32'd0, bn, wn, cy, cn, da);
        check("copy_busy_cycles", 32'(bn), 32'd8);
        check("copy_we_cycles",   32'(wn), 32'd4);
        check("copy_done_cycle",  32'(cy), 32'd9);
        check("copy_count",       32'(cn), 32'd4);
        check("copy_done_pulse",  32'(da), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("copy_dst", ram[100 + i], 32'(i + 1));
            check("copy_src", ram[i],       32'(i + 1));
        end

        // FILL across the top of the address space
        run_op(2'd1, 0, 1022, 4, 32'hDEADBEEF, bn, wn, cy, cn, da);
        check("fill_busy_cycles", 32'(bn), 32'd4);
        check("fill_we_cycles",   32'(wn), 32'd4);
        check("fill_count",       32'(cn), 32'd4);
        check("fill_1022", ram[1022], 32'hDEADBEEF);
        check("fill_1023", ram[1023], 32'hDEADBEEF);
        check("fill_0",    ram[0],    32'hDEADBEEF);
        check("fill_1",    ram[1],    32'hDEADBEEF);
        check("fill_2_untouched", ram[2], 32'd3);

        // SUM with 32-bit wraparound
        poke(10, 32'hFFFFFFFF);
        poke(11, 32'd2);
        poke(12, 32'd5);
        run_op(2'd2, 10, 0, 3, 32'd0, bn, wn, cy, cn, da);
        check("sum_busy_cycles", 32'(bn), 32'd3);
        check("sum_we_cycles",   32'(wn), 32'd0);
        check("sum_result",      result,  32'h00000006);
        check("sum_count",       32'(cn), 32'd3);

        // Zero-length and reserved ops: done straight after start, result untouched
        run_op(2'd0, 0, 50, 0, 32'd0, bn, wn, cy, cn, da);
        check("len0_done_cycle", 32'(cy), 32'd1);
        check("len0_we_cycles",  32'(wn), 32'd0);
        check("len0_count",      32'(cn), 32'd0);
        check("len0_result_held", result, 32'h00000006);
        run_op(2'd3, 0, 50, 5, 32'hFFFF0000, bn, wn, cy, cn, da);
        check("op3_done_cycle", 32'(cy), 32'd1);
        check("op3_we_cycles",  32'(wn), 32'd0);
        check("op3_count",      32'(cn), 32'd0);
        check("op3_ram_50",     ram[50], 32'd0);

        // COPY 8 words aborted in the 3rd write; a stray start while busy is ignored
        for (int i = 0; i < 8; i++) poke(200 + i, 32'h100 + 32'(i));
        @(negedge clk);
        op = 2'd0; src_addr = 10'd200; dst_addr = 10'd300; len = 11'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wcount = 0;
        hit = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            start = (k == 2);
            if (k == 2) begin
                op = 2'd1; fill_data = 32'hBAD0BAD0; dst_addr = 10'd300;
            end
            if (mem_we) wcount++;
            if (mem_we && wcount == 3) begin
                abort = 1'b1;
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("abort_reached", 32'(hit), 32'd1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_done",  32'(done),   32'd1);
        check("abort_count", 32'(count),  32'd3);
        check("abort_we",    32'(mem_we), 32'd0);
        for (int i = 0; i < 3; i++) check("abort_written", ram[300 + i], 32'h100 + 32'(i));
        for (int i = 3; i < 8; i++) check("abort_unwritten", ram[300 + i], 32'd0);
        @(negedge clk);
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_done", 32'(done), 32'd0);

        // FILL 16 words with an asynchronous reset between edges in the 5th write
        @(negedge clk);
        op = 2'd1; dst_addr = 10'd500; len = 11'd16; fill_data = 32'h55AA55AA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid_we_before", 32'(mem_we), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rstmid_we",     32'(mem_we),   32'd0);
        check("rstmid_busy",   32'(busy),     32'd0);
        check("rstmid_count",  32'(count),    32'd0);
        check("rstmid_addr",   32'(mem_addr), 32'd0);
        check("rstmid_din",    mem_din,       32'd0);
        check("rstmid_result", result,        32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rstmid_idle_busy", 32'(busy), 32'd0);
        check("rstmid_idle_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) check("rstmid_written", ram[500 + i], 32'h55AA55AA);
        check("rstmid_504", ram[504], 32'd0);
        check("rstmid_515", ram[515], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_dma_engine.md
Name: ram_dma_engine

Overview:
- Bus initiator that drives the data-memory port (addr/we/Din/Dout) of the 1024x32 RAM, so the RAM can be bulk-processed without the CPU datapath.
- Three operations, started by a one-cycle start pulse: block copy, block fill with a constant, and 32-bit wrapping checksum of a block.
- Sits beside the CPU; a top-level mux grants it the RAM port while busy=1.

Parameters:
- AW, 10, RAM word-address width; the address space is 2^AW words.
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- op  in  2  operation: 0 = COPY, 1 = FILL, 2 = SUM, 3 = reserved (treated as a zero-length operation).
- src_addr  in  AW  first source word (COPY, SUM); latched at start.
- dst_addr  in  AW  first destination word (COPY, FILL); latched at start.
- len  in  AW+1  word count, 0..1024; latched at start.
- fill_data  in  DW  FILL pattern; latched at start.
- abort  in  1  synchronous stop request.
- busy  out  1  high while in READ or WRITE.
- done  out  1  one-cycle pulse in the DONE state.
- result  out  DW  SUM accumulator; holds its value until the next start.
- count  out  AW+1  number of words completed so far.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_din  out  DW  RAM write data.
- mem_dout  in  DW  RAM read data; combinational from mem_addr in the same cycle.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, mem_we, mem_addr, mem_din, result and count all 0; internal index and data register cleared.
- mem_we is decoded only from registered state, so it never glitches and drops to 0 immediately on reset.
- States and transitions:
  - IDLE: start=1 latches the inputs and clears count. If len=0 or op=3, go to DONE. Otherwise go to READ (COPY, SUM) or WRITE (FILL). If op=2 (SUM), result is also cleared.
  - READ: mem_addr=(src+i) mod 2^AW, mem_we=0. At the clock edge, mem_dout is captured into the data register.
    - COPY: go to WRITE.
    - SUM: result += mem_dout (mod 2^32), i++, count++. If i reaches len, go to DONE; otherwise stay in READ.
  - WRITE: mem_addr=(dst+i) mod 2^AW, mem_we=1. mem_din = the data register (COPY) or fill_data (FILL). At the clock edge, i++ and count++. If i reaches len, go to DONE; otherwise go to READ (COPY) or stay in WRITE (FILL).
  - DONE: done=1, busy=0, mem_we=0. Return to IDLE next cycle.
- Latency, with start sampled at edge 0:
  - The first memory cycle is the cycle after edge 0.
  - COPY: 2N busy cycles. FILL and SUM: N busy cycles.
  - done is high in the cycle immediately after the last access.
- Addresses wrap modulo 1024 (e.g. src=1023, len=2 reads 1023 then 0).
- COPY always runs in ascending order. Overlapping regions with dst>src intentionally replicate data (defined behaviour, not an error).
- start while not in IDLE is ignored. start in DONE is ignored.
- abort=1 at an edge in READ or WRITE goes to DONE.
  - The access driven during that cycle completes: a WRITE cycle still commits its word, and count includes it.
  - A READ of a COPY aborted at that edge is not written.
  - abort in IDLE or DONE has no effect.
- Reset mid-operation: the operation is abandoned, no further writes occur, and all outputs return to their reset values.
- In IDLE and DONE: mem_addr=0 and mem_din=0.

Decomposition:
- Shared package: op encodings (OP_COPY=0, OP_FILL=1, OP_SUM=2) and state encodings (IDLE, READ, WRITE, DONE); AW and DW defaults.
- A separate sub-module is not warranted: one FSM plus an index/accumulator datapath. The address generator stays inline.

Test Plan:
- Preload RAM[0..3]=1,2,3,4. COPY src=0, dst=100, len=4 -> RAM[100..103]=1,2,3,4; busy for 8 cycles; done 1 cycle later; count=4; RAM[0..3] unchanged.
- FILL dst=1022, fill_data=0xDEADBEEF, len=4 -> RAM[1022], [1023], [0], [1] = 0xDEADBEEF; busy for 4 cycles; mem_we high exactly 4 cycles.
- SUM src=10, len=3 with RAM[10..12]=0xFFFFFFFF, 2, 5 -> result=0x00000006; no write cycles.
- len=0 (any op) and op=3 -> done pulses 1 cycle after start; mem_we never asserted; count=0.
- COPY len=8: abort in the 3rd WRITE cycle -> exactly 3 words written; count=3; done the next cycle. A start pulse during busy in the same run is ignored.
- FILL len=16: rst=0 mid-run (between edges) -> mem_we and busy drop immediately; after release, the block is in IDLE and only the words written before reset differ.
